// File: rtl/pc_stack.sv
// Program counter with an integrated circular return-address stack, stall and conditional branch.
// Define PC_STACK_ERR_EN to refuse CALL-on-full and flag overflow/underflow instead of wrapping.
module pc_stack #(
  parameter int                         INSTR_ADDR_SIZE = 8,
  parameter int                         STACK_DEPTH     = 4,
  parameter logic [INSTR_ADDR_SIZE-1:0] RESET_VECTOR    = '0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       stall,
  input  logic [4:0]                 jump_code,
  input  logic [INSTR_ADDR_SIZE-1:0] jump_address,
  input  logic                       cond,
  output logic [INSTR_ADDR_SIZE-1:0] instruction_address,
  output logic [INSTR_ADDR_SIZE-1:0] top_of_stack,
  output logic                       stack_empty,
  output logic                       stack_full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W   = $clog2(STACK_DEPTH);

  localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STACK_DEPTH);
  localparam logic [PTR_W-1:0]   LAST_PTR   = PTR_W'(STACK_DEPTH - 1);

  localparam logic [4:0] OP_SRESET = 5'd0;
  localparam logic [4:0] OP_JUMP   = 5'd1;
  localparam logic [4:0] OP_RET    = 5'd2;
  localparam logic [4:0] OP_CALL   = 5'd4;
  localparam logic [4:0] OP_BRANCH = 5'd5;

  logic [INSTR_ADDR_SIZE-1:0] pc_q, pc_d;
  logic [INSTR_ADDR_SIZE-1:0] mem_q [STACK_DEPTH];
  logic [INSTR_ADDR_SIZE-1:0] mem_d [STACK_DEPTH];
  logic [DEPTH_W-1:0]         depth_q, depth_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic                       overflow_q, overflow_d;
  logic                       underflow_q, underflow_d;

  logic [INSTR_ADDR_SIZE-1:0] pc_inc;
  logic [PTR_W-1:0]           ptr_next;
  logic [PTR_W-1:0]           top_idx;

  // wr_ptr_q is the next slot to write; the top entry sits one slot behind it, modulo depth.
  assign pc_inc   = pc_q + INSTR_ADDR_SIZE'(1);
  assign ptr_next = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
  assign top_idx  = (wr_ptr_q == '0) ? LAST_PTR : wr_ptr_q - PTR_W'(1);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    pc_d        = pc_q;
    mem_d       = mem_q;
    depth_d     = depth_q;
    wr_ptr_d    = wr_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (!stall) begin
      case (jump_code)
        OP_SRESET: begin
          pc_d     = RESET_VECTOR;
          depth_d  = '0;
          wr_ptr_d = '0;
        end
        OP_JUMP: pc_d = jump_address;
        OP_RET: begin
          if (depth_q != '0) begin
            pc_d     = mem_q[top_idx];
            wr_ptr_d = top_idx;
            depth_d  = depth_q - DEPTH_W'(1);
          end else begin
            pc_d = pc_inc;
`ifdef PC_STACK_ERR_EN
            underflow_d = 1'b1;
`endif
          end
        end
        OP_CALL: begin
          pc_d = jump_address;
          if (depth_q != FULL_DEPTH) begin
            mem_d[wr_ptr_q] = pc_inc;
            wr_ptr_d        = ptr_next;
            depth_d         = depth_q + DEPTH_W'(1);
          end else begin
`ifdef PC_STACK_ERR_EN
            overflow_d = 1'b1;
`else
            // Full: the write slot holds the oldest entry, so it is overwritten.
            mem_d[wr_ptr_q] = pc_inc;
            wr_ptr_d        = ptr_next;
`endif
          end
        end
        OP_BRANCH: pc_d = cond ? jump_address : pc_inc;
        default:   pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q        <= RESET_VECTOR;
      depth_q     <= '0;
      wr_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      // NOTE: the stack storage is reset too, so every entry reads back as zero after RESET.
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      pc_q        <= pc_d;
      mem_q       <= mem_d;
      depth_q     <= depth_d;
      wr_ptr_q    <= wr_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign instruction_address = pc_q;
  assign stack_empty         = (depth_q == '0);
  assign stack_full          = (depth_q == FULL_DEPTH);
  assign top_of_stack        = stack_empty ? '0 : mem_q[top_idx];
  assign overflow            = overflow_q;
  assign underflow           = underflow_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack (default parameters); expectations follow PC_STACK_ERR_EN when defined.
module tb_pc_stack;

`ifdef PC_STACK_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  localparam logic [4:0] SRST = 5'd0, JMP = 5'd1, RET = 5'd2, INC = 5'd3, CALL = 5'd4, BR = 5'd5;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       stall;
  logic [4:0] jump_code;
  logic [7:0] jump_address;
  logic       cond;
  logic [7:0] instruction_address;
  logic [7:0] top_of_stack;
  logic       stack_empty;
  logic       stack_full;
  logic       overflow;
  logic       underflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic       stl;
    logic [4:0] op;
    logic [7:0] addr;
    logic       cnd;
    logic [7:0] pc;
    logic [7:0] tos;
    logic       emp;
    logic       ful;
    logic       ovf;
    logic       unf;
  } vec_t;

  pc_stack dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .stall               (stall),
    .jump_code           (jump_code),
    .jump_address        (jump_address),
    .cond                (cond),
    .instruction_address (instruction_address),
    .top_of_stack        (top_of_stack),
    .stack_empty         (stack_empty),
    .stack_full          (stack_full),
    .overflow            (overflow),
    .underflow           (underflow)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic rst, input logic stl, input logic [4:0] op,
                              input logic [7:0] addr, input logic cnd, input logic [7:0] pc,
                              input logic [7:0] tos, input logic emp, input logic ful,
                              input logic ovf, input logic unf);
    vec_t v;
    v.rst = rst; v.stl = stl; v.op = op; v.addr = addr; v.cnd = cnd;
    v.pc = pc; v.tos = tos; v.emp = emp; v.ful = ful; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  // Drive one vector, let one rising edge pass, and settle 1 ns after it.
  task automatic apply(input vec_t v);
    RESET        = v.rst;
    stall        = v.stl;
    jump_code    = v.op;
    jump_address = v.addr;
    cond         = v.cnd;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    vec_t v[$];
    v.push_back(mk(1, 1, JMP, 8'h99, 0, 8'h00, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, INC, 8'h00, 0, 8'h01, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, INC, 8'h00, 0, 8'h02, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, INC, 8'h00, 0, 8'h03, 8'h00, 1, 0, 0, 0));
    foreach (v[i]) begin
      apply(v[i]);
      checks++;
      if ({instruction_address, top_of_stack, stack_empty, stack_full, overflow, underflow} !==
          {v[i].pc, v[i].tos, v[i].emp, v[i].ful, v[i].ovf, v[i].unf}) begin
        errors++;
        $display("FAIL reset step %0d: got pc=%h tos=%h e=%b f=%b o=%b u=%b, want pc=%h tos=%h e=%b f=%b o=%b u=%b",
                 i, instruction_address, top_of_stack, stack_empty, stack_full, overflow, underflow,
                 v[i].pc, v[i].tos, v[i].emp, v[i].ful, v[i].ovf, v[i].unf);
      end
    end
  endtask

  task automatic test_nested_call();
    vec_t v[$];
    v.push_back(mk(0, 0, JMP,  8'h10, 0, 8'h10, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, CALL, 8'h40, 0, 8'h40, 8'h11, 0, 0, 0, 0));
    v.push_back(mk(0, 0, CALL, 8'h80, 0, 8'h80, 8'h41, 0, 0, 0, 0));
    v.push_back(mk(0, 0, RET,  8'h00, 0, 8'h41, 8'h11, 0, 0, 0, 0));
    v.push_back(mk(0, 0, RET,  8'h00, 0, 8'h11, 8'h00, 1, 0, 0, 0));
    foreach (v[i]) begin
      apply(v[i]);
      checks++;
      if ({instruction_address, top_of_stack, stack_empty, stack_full, overflow, underflow} !==
          {v[i].pc, v[i].tos, v[i].emp, v[i].ful, v[i].ovf, v[i].unf}) begin
        errors++;
        $display("FAIL nested_call step %0d: got pc=%h tos=%h e=%b f=%b o=%b u=%b, want pc=%h tos=%h e=%b f=%b o=%b u=%b",
                 i, instruction_address, top_of_stack, stack_empty, stack_full, overflow, underflow,
                 v[i].pc, v[i].tos, v[i].emp, v[i].ful, v[i].ovf, v[i].unf);
      end
    end
  endtask

  task automatic test_branch_stall();
    vec_t v[$];
    v.push_back(mk(0, 0, JMP,  8'h05, 0, 8'h05, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, BR,   8'h20, 0, 8'h06, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, BR,   8'h20, 1, 8'h20, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 1, JMP,  8'h99, 0, 8'h20, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 1, JMP,  8'h99, 0, 8'h20, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 1, JMP,  8'h99, 0, 8'h20, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 1, CALL, 8'h77, 0, 8'h20, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, INC,  8'h99, 0, 8'h21, 8'h00, 1, 0, 0, 0));
    foreach (v[i]) begin
      apply(v[i]);
      checks++;
      if ({instruction_address, top_of_stack, stack_empty, stack_full, overflow, underflow} !==
          {v[i].pc, v[i].tos, v[i].emp, v[i].ful, v[i].ovf, v[i].unf}) begin
        errors++;
        $display("FAIL branch_stall step %0d: got pc=%h tos=%h e=%b f=%b o=%b u=%b, want pc=%h tos=%h e=%b f=%b o=%b u=%b",
                 i, instruction_address, top_of_stack, stack_empty, stack_full, overflow, underflow,
                 v[i].pc, v[i].tos, v[i].emp, v[i].ful, v[i].ovf, v[i].unf);
      end
    end
  endtask

  task automatic test_overflow();
    vec_t v[$];
    v.push_back(mk(1, 0, INC,  8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, JMP,  8'h10, 0, 8'h10, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, CALL, 8'h20, 0, 8'h20, 8'h11, 0, 0, 0, 0));
    v.push_back(mk(0, 0, CALL, 8'h30, 0, 8'h30, 8'h21, 0, 0, 0, 0));
    v.push_back(mk(0, 0, CALL, 8'h40, 0, 8'h40, 8'h31, 0, 0, 0, 0));
    v.push_back(mk(0, 0, CALL, 8'h50, 0, 8'h50, 8'h41, 0, 1, 0, 0));
    v.push_back(mk(0, 0, CALL, 8'h60, 0, 8'h60, ERR ? 8'h41 : 8'h51, 0, 1, ERR, 0));
    v.push_back(mk(0, 0, RET,  8'h00, 0, ERR ? 8'h41 : 8'h51, ERR ? 8'h31 : 8'h41, 0, 0, ERR, 0));
    v.push_back(mk(0, 0, RET,  8'h00, 0, ERR ? 8'h31 : 8'h41, ERR ? 8'h21 : 8'h31, 0, 0, ERR, 0));
    v.push_back(mk(0, 0, RET,  8'h00, 0, ERR ? 8'h21 : 8'h31, ERR ? 8'h11 : 8'h21, 0, 0, ERR, 0));
    v.push_back(mk(0, 0, RET,  8'h00, 0, ERR ? 8'h11 : 8'h21, 8'h00, 1, 0, ERR, 0));
    v.push_back(mk(0, 0, RET,  8'h00, 0, ERR ? 8'h12 : 8'h22, 8'h00, 1, 0, ERR, ERR));
    v.push_back(mk(0, 0, SRST, 8'h00, 0, 8'h00, 8'h00, 1, 0, ERR, ERR));
    v.push_back(mk(1, 0, INC,  8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0));
    foreach (v[i]) begin
      apply(v[i]);
      checks++;
      if ({instruction_address, top_of_stack, stack_empty, stack_full, overflow, underflow} !==
          {v[i].pc, v[i].tos, v[i].emp, v[i].ful, v[i].ovf, v[i].unf}) begin
        errors++;
        $display("FAIL overflow step %0d: got pc=%h tos=%h e=%b f=%b o=%b u=%b, want pc=%h tos=%h e=%b f=%b o=%b u=%b",
                 i, instruction_address, top_of_stack, stack_empty, stack_full, overflow, underflow,
                 v[i].pc, v[i].tos, v[i].emp, v[i].ful, v[i].ovf, v[i].unf);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    v.push_back(mk(0, 0, JMP,  8'h30, 0, 8'h30, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, CALL, 8'h50, 0, 8'h50, 8'h31, 0, 0, 0, 0));
    v.push_back(mk(0, 0, RET,  8'h00, 0, 8'h31, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, CALL, 8'h60, 0, 8'h60, 8'h32, 0, 0, 0, 0));
    v.push_back(mk(0, 0, RET,  8'h00, 0, 8'h32, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, CALL, 8'h70, 0, 8'h70, 8'h33, 0, 0, 0, 0));
    v.push_back(mk(0, 0, CALL, 8'h80, 0, 8'h80, 8'h71, 0, 0, 0, 0));
    v.push_back(mk(0, 0, RET,  8'h00, 0, 8'h71, 8'h33, 0, 0, 0, 0));
    v.push_back(mk(0, 0, RET,  8'h00, 0, 8'h33, 8'h00, 1, 0, 0, 0));
    foreach (v[i]) begin
      apply(v[i]);
      checks++;
      if ({instruction_address, top_of_stack, stack_empty, stack_full, overflow, underflow} !==
          {v[i].pc, v[i].tos, v[i].emp, v[i].ful, v[i].ovf, v[i].unf}) begin
        errors++;
        $display("FAIL back_to_back step %0d: got pc=%h tos=%h e=%b f=%b o=%b u=%b, want pc=%h tos=%h e=%b f=%b o=%b u=%b",
                 i, instruction_address, top_of_stack, stack_empty, stack_full, overflow, underflow,
                 v[i].pc, v[i].tos, v[i].emp, v[i].ful, v[i].ovf, v[i].unf);
      end
    end
  endtask

  task automatic test_wrap();
    vec_t v[$];
    v.push_back(mk(0, 0, JMP,   8'hFF, 0, 8'hFF, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, INC,   8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, JMP,   8'hFF, 0, 8'hFF, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, CALL,  8'h10, 0, 8'h10, 8'h00, 0, 0, 0, 0));
    v.push_back(mk(0, 0, RET,   8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 5'd7,  8'h55, 1, 8'h01, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 5'd31, 8'h55, 1, 8'h02, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 5'd6,  8'h55, 1, 8'h03, 8'h00, 1, 0, 0, 0));
    foreach (v[i]) begin
      apply(v[i]);
      checks++;
      if ({instruction_address, top_of_stack, stack_empty, stack_full, overflow, underflow} !==
          {v[i].pc, v[i].tos, v[i].emp, v[i].ful, v[i].ovf, v[i].unf}) begin
        errors++;
        $display("FAIL wrap step %0d: got pc=%h tos=%h e=%b f=%b o=%b u=%b, want pc=%h tos=%h e=%b f=%b o=%b u=%b",
                 i, instruction_address, top_of_stack, stack_empty, stack_full, overflow, underflow,
                 v[i].pc, v[i].tos, v[i].emp, v[i].ful, v[i].ovf, v[i].unf);
      end
    end
  endtask

  task automatic test_mid_reset();
    vec_t v[$];
    v.push_back(mk(0, 0, RET,  8'h00, 0, 8'h04, 8'h00, 1, 0, 0, ERR));
    v.push_back(mk(0, 0, CALL, 8'h20, 0, 8'h20, 8'h05, 0, 0, 0, ERR));
    v.push_back(mk(0, 0, CALL, 8'h30, 0, 8'h30, 8'h21, 0, 0, 0, ERR));
    v.push_back(mk(0, 0, CALL, 8'h40, 0, 8'h40, 8'h31, 0, 0, 0, ERR));
    v.push_back(mk(1, 0, CALL, 8'h50, 0, 8'h00, 8'h00, 1, 0, 0, 0));
    v.push_back(mk(0, 0, RET,  8'h00, 0, 8'h01, 8'h00, 1, 0, 0, ERR));
    v.push_back(mk(0, 0, CALL, 8'h60, 0, 8'h60, 8'h02, 0, 0, 0, ERR));
    v.push_back(mk(1, 1, RET,  8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0));
    foreach (v[i]) begin
      apply(v[i]);
      checks++;
      if ({instruction_address, top_of_stack, stack_empty, stack_full, overflow, underflow} !==
          {v[i].pc, v[i].tos, v[i].emp, v[i].ful, v[i].ovf, v[i].unf}) begin
        errors++;
        $display("FAIL mid_reset step %0d: got pc=%h tos=%h e=%b f=%b o=%b u=%b, want pc=%h tos=%h e=%b f=%b o=%b u=%b",
                 i, instruction_address, top_of_stack, stack_empty, stack_full, overflow, underflow,
                 v[i].pc, v[i].tos, v[i].emp, v[i].ful, v[i].ovf, v[i].unf);
      end
    end
  endtask

  initial begin
    RESET        = 1'b1;
    stall        = 1'b1;
    jump_code    = JMP;
    jump_address = 8'h99;
    cond         = 1'b0;
    test_reset();
    test_nested_call();
    test_branch_stall();
    test_overflow();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with an integrated hardware return-address stack, stall input and conditional branch. It replaces the single-return-register PC: the sequencer issues a 5-bit jump code per cycle and `pc_stack` produces the next instruction address. It holds its own call/return history, so callers no longer supply `return_address`. It sits between the decoder/branch unit and the instruction memory address port.

## Interface
- `INSTR_ADDR_SIZE`, 8: width of every address.
- `STACK_DEPTH`, 4: return-stack entries, ≥2.
- `RESET_VECTOR`, 0: address loaded on reset and by the RESET opcode.

- `CLK`  in  1  clock, all state on rising edge.
- `RESET`  in  1  synchronous, active-high reset; one clock; overrides every other input.
- `stall`  in  1  1 = hold all state; opcode ignored.
- `jump_code`  in  5  opcode.
- `jump_address`  in  INSTR_ADDR_SIZE  target for JUMP/CALL/BRANCH.
- `cond`  in  1  branch condition for BRANCH.
- `instruction_address`  out  INSTR_ADDR_SIZE  registered PC.
- `top_of_stack`  out  INSTR_ADDR_SIZE  current top entry; 0 when empty.
- `stack_empty`  out  1  depth == 0.
- `stack_full`  out  1  depth == STACK_DEPTH.
- `overflow`  out  1  sticky CALL-on-full flag.
- `underflow`  out  1  sticky RET-on-empty flag.

## Operation
- Opcodes:
  - 0 SRESET: PC ← RESET_VECTOR; depth ← 0.
  - 1 JUMP: PC ← jump_address.
  - 2 RET: pop; PC ← popped entry.
  - 3 INC: PC ← PC+1.
  - 4 CALL: push PC+1; PC ← jump_address.
  - 5 BRANCH: PC ← cond ? jump_address : PC+1.
  - 6–31: treated as INC.
- `RESET`=1:
  - PC ← RESET_VECTOR; depth ← 0; overflow, underflow ← 0.
  - All storage entries read back as 0 afterwards.
- `stall`=1 (RESET=0): PC, stack, depth and flags all hold.
- SRESET leaves overflow/underflow unchanged; only the `RESET` port clears them.
- Arithmetic is modulo 2^INSTR_ADDR_SIZE:
  - PC+1 from all-ones yields 0.
  - CALL at PC = all-ones pushes 0.
- Stack is LIFO; depth counter is clog2(STACK_DEPTH+1) bits.
- Push and pop never occur in the same cycle; each opcode does at most one.
- CALL on full and RET on empty: see Configuration.
- `top_of_stack`, `stack_empty` and `stack_full` are functions of registered state only. They update in the same cycle as PC.

## Timing
- Registered outputs: the effect of an opcode sampled at edge N is visible after edge N.
- Latency is 1 cycle for all opcodes; no multi-cycle states.
- Back-to-back CALL/RET every cycle is supported, with no bubbles.
- RET in the cycle immediately after CALL returns the address just pushed.
- Reset mid-operation (any depth, any opcode, stalled or not) takes effect at that edge.
- `stall` asserted with `RESET`: reset wins.

## Configuration
- Macro: `PC_STACK_ERR_EN`.
- Defined:
  - CALL on full: no push, depth stays STACK_DEPTH, PC ← jump_address, overflow ← 1 (sticky).
  - RET on empty: PC ← PC+1, depth stays 0, underflow ← 1 (sticky).
- Undefined:
  - The stack is circular. CALL on full overwrites the oldest entry, keeps depth at STACK_DEPTH, and the newest entry becomes top.
  - RET on empty: PC ← PC+1.
  - `overflow`/`underflow` are tied to 0.

## Test plan
- Reset/increment: `RESET` 1 cycle, then INC ×3 (default parameters) -> PC 0,1,2,3; stack_empty=1; top_of_stack=0.
- Nested call/return: PC=0x10 CALL 0x40, at 0x40 CALL 0x80, then RET, RET -> PC 0x40, 0x80, 0x41, 0x11; stack_empty=1 at end.
- Branch and stall: BRANCH 0x20 with cond=0 from 0x05 -> 0x06; with cond=1 -> 0x20. stall=1 for 3 cycles with JUMP 0x99 on jump_code -> PC holds 0x20.
- Overflow: 5 CALLs with STACK_DEPTH=4.
  - With `PC_STACK_ERR_EN`: overflow=1, stack_full=1, 4 RETs return the first 4 pushes, 5th RET sets underflow=1 and PC increments.
  - Without: 4 RETs return pushes 5,4,3,2.
- Wrap/reset: CALL at PC=0xFF pushes 0x00. JUMP 0xFF then INC -> 0x00. `RESET` asserted mid-sequence at depth 3 -> PC=RESET_VECTOR, depth 0, flags 0 next cycle.
